uart_rx_fifo_wr_ctrl: RTL

Finite state machine that takes bytes from the UART RX and writes them into the shared FIFO, one write strobe per received word. It is the write-side counterpart of the FIFO read controller feeding the UART TX. It yields to an in-progress FIFO read and holds each word while the FIFO is full, up to a bounded timeout. Dropped words and read/write collisions are reported through sticky status outputs. All outputs are registered.

---
 rtl/uart_rx_fifo_wr_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_wr_ctrl.sv
// uart_rx_fifo_wr_ctrl: moves words from the UART RX into the shared FIFO.
// Each captured word waits for a free slot (not full, no read in progress).
// While the FIFO stays full, the word is held for a bounded time and then dropped.
// Dropped words and read/write strobe overlaps are kept as sticky status.
module uart_rx_fifo_wr_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_data_valid,
   input  logic             fifo_full,
   input  logic             read_fifo_n,
   input  logic             status_clr,
   output logic             write_fifo_n,
   output logic [WIDTH-1:0] fifo_wr_data,
   output logic             rx_overflow,
   output logic [7:0]       drop_count,
   output logic             rd_wr_collision
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SLOT = 2'd1,
      WRITE     = 2'd2,
      RECOVER   = 2'd3
   } state_t;

   localparam logic [5:0] TMO = 6'(TIMEOUT);

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             wr_n_q, wr_n_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drop_q, drop_d;
   logic             coll_q, coll_d;

   // Drop events seen this cycle. An overrun and a timeout can coincide, so
   // this can reach two.
   logic [1:0]       drops;
   logic [8:0]       drop_sum;
   logic [7:0]       drop_base;

   // Next-state, capture, timeout counter and drop detection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      drops   = 2'd0;
      case (state_q)
         IDLE: begin
            if (rx_data_valid) begin
               data_d  = rx_data;
               cnt_d   = 6'd0;
               state_d = WAIT_SLOT;
            end
         end
         WAIT_SLOT: begin
            // An incoming word cannot be buffered while one is held.
            if (rx_data_valid) drops = drops + 2'd1;
            if (fifo_full) begin
               if (cnt_q < TMO) begin
                  cnt_d = cnt_q + 6'd1;
               end else begin
                  drops   = drops + 2'd1;
                  state_d = IDLE;
               end
            end else if (!read_fifo_n) begin
               state_d = WAIT_SLOT;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (rx_data_valid) drops = drops + 2'd1;
            state_d = RECOVER;
         end
         RECOVER: begin
            if (rx_data_valid) begin
               data_d  = rx_data;
               cnt_d   = 6'd0;
               state_d = WAIT_SLOT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The strobe is decoded from the next state so it is registered.
      wr_n_d = (state_d != WRITE);
   end

   // Sticky status. A clear discards old history but keeps this cycle's events.
   always_comb begin
      drop_base = status_clr ? 8'd0 : drop_q;
      drop_sum  = {1'b0, drop_base} + {7'd0, drops};
      drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      ovf_d     = (status_clr ? 1'b0 : ovf_q) | (drops != 2'd0);
      coll_d    = (status_clr ? 1'b0 : coll_q) | (!read_fifo_n && !wr_n_q);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         wr_n_q  <= 1'b1;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 8'd0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_n_q  <= wr_n_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         coll_q  <= coll_d;
      end
   end

   assign write_fifo_n    = wr_n_q;
   assign fifo_wr_data    = data_q;
   assign rx_overflow     = ovf_q;
   assign drop_count      = drop_q;
   assign rd_wr_collision = coll_q;

endmodule
